// File: rtl/secret_code_gen.sv
// secret_code_gen: rejection-samples LFSR output into a packed NUM_PEGS x 3-bit Mastermind secret code.
// Latency: NUM_PEGS FILL cycles with no rejects, +1 cycle per reject, NUM_PEGS*MAX_REJECT worst case.
// Backpressure: none; start is ignored while busy and the finished code is held in DONE until the next start.
// Optional feature macro: SECRET_CODE_UNIQUE_COLORS_EN (no colour may repeat within one code).
module secret_code_gen #(
   parameter int NUM_PEGS   = 4,
   parameter int NUM_COLORS = 6,
   parameter int RAND_W     = 8,
   parameter int MAX_REJECT = 8
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [RAND_W-1:0]     rand_in,
   output logic                  rand_switch,
   output logic [3*NUM_PEGS-1:0] code,
   output logic                  code_valid,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
   localparam int         REJ_W = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;
   localparam logic [3:0] NCOL  = 4'(NUM_COLORS);

   if (NUM_COLORS < 1 || NUM_COLORS > 8) begin : g_bad_colors
      $error("secret_code_gen: NUM_COLORS must be in 1..8");
   end

   state_t                state_q, state_d;
   logic [3*NUM_PEGS-1:0] code_q, code_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [REJ_W-1:0]      rej_q, rej_d;

   // The bench-facing LFSR bus is Q[8:1]; its three lowest taps (vector bits 2:0) form the candidate.
   logic [2:0] cand;
   logic       in_range;
   logic       is_dup;
   logic       accept;
   logic       force_acc;
   logic [2:0] force_val;
   logic [2:0] wr_val;
   logic       unused_rand;

   assign cand        = rand_in[2:0];
   assign unused_rand = ^rand_in[RAND_W-1:3];

`ifdef SECRET_CODE_UNIQUE_COLORS_EN
   if (NUM_COLORS < NUM_PEGS) begin : g_bad_unique
      $error("secret_code_gen: unique colours need NUM_COLORS >= NUM_PEGS");
   end

   logic [7:0] used;

   // Track colours already placed below the current index; a forced accept takes the smallest free one.
   always_comb begin
      used      = '0;
      force_val = '0;
      for (int i = 0; i < NUM_PEGS; i++) begin
         if (IDX_W'(i) < idx_q) used[code_q[3*i +: 3]] = 1'b1;
      end
      for (int k = NUM_COLORS - 1; k >= 0; k--) begin
         if (!used[k]) force_val = 3'(k);
      end
      is_dup = used[cand];
   end
`else
   // Repeats allowed; an out-of-range candidate folds back into range (c - NUM_COLORS for 6 colours).
   assign is_dup    = 1'b0;
   assign force_val = 3'(int'(cand) % NUM_COLORS);
`endif

   assign in_range  = ({1'b0, cand} < NCOL);
   assign accept    = in_range && !is_dup;
   assign force_acc = !accept && (rej_q == REJ_W'(MAX_REJECT - 1));
   assign wr_val    = accept ? cand : force_val;

   // Next-state: start (re)launches a fill from IDLE/DONE, FILL writes one peg per accepted sample.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      idx_d   = idx_q;
      rej_d   = rej_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = FILL;
               code_d  = '0;
               idx_d   = '0;
               rej_d   = '0;
            end
         end
         FILL: begin
            if (accept || force_acc) begin
               for (int i = 0; i < NUM_PEGS; i++) begin
                  if (IDX_W'(i) == idx_q) code_d[3*i +: 3] = wr_val;
               end
               rej_d = '0;
               if (idx_q == IDX_W'(NUM_PEGS - 1)) begin
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               rej_d = rej_q + REJ_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; a reset mid-fill discards the partial code.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= IDLE;
         code_q  <= '0;
         idx_q   <= '0;
         rej_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         rej_q   <= rej_d;
      end
   end

   assign code        = code_q;
   assign code_valid  = (state_q == DONE);
   assign busy        = (state_q == FILL);
   assign rand_switch = (state_q == FILL);

endmodule

// File: tb/tb_secret_code_gen.sv
// tb_secret_code_gen: randomized and directed self-checking bench for secret_code_gen.
// Expected codes and fill lengths come from a queue-based model of the sampling rules.
// Honours SECRET_CODE_UNIQUE_COLORS_EN the same way as the design.
`timescale 1ns/1ps
module tb_secret_code_gen;

   localparam int NUM_PEGS   = 4;
   localparam int NUM_COLORS = 6;
   localparam int RAND_W     = 8;
   localparam int MAX_REJECT = 8;
   localparam int CW         = 3 * NUM_PEGS;
`ifdef SECRET_CODE_UNIQUE_COLORS_EN
   localparam bit UNIQ = 1'b1;
`else
   localparam bit UNIQ = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              Reset;
   logic              start;
   logic [RAND_W-1:0] rand_in;
   logic              rand_switch;
   logic [CW-1:0]     code;
   logic              code_valid;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   secret_code_gen #(
      .NUM_PEGS  (NUM_PEGS),
      .NUM_COLORS(NUM_COLORS),
      .RAND_W    (RAND_W),
      .MAX_REJECT(MAX_REJECT)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .start      (start),
      .rand_in    (rand_in),
      .rand_switch(rand_switch),
      .code       (code),
      .code_valid (code_valid),
      .busy       (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: walk the sample list, keep accepted colours in a queue, force after MAX_REJECT misses.
   function automatic void model(input logic [7:0] smp[$], output logic [CW-1:0] exp_code,
                                 output int exp_n);
      int pegs[$];
      int rej;
      int c;
      int pick;
      bit ok;
      rej   = 0;
      exp_n = 0;
      while (pegs.size() < NUM_PEGS) begin
         c = (exp_n < smp.size()) ? int'(smp[exp_n] & 8'h07) : 7;
         exp_n++;
         ok = (c < NUM_COLORS);
         if (UNIQ) foreach (pegs[j]) if (pegs[j] == c) ok = 0;
         if (ok) begin
            pegs.push_back(c);
            rej = 0;
         end else begin
            rej++;
            if (rej == MAX_REJECT) begin
               if (UNIQ) begin
                  pick = -1;
                  for (int col = 0; col < NUM_COLORS && pick < 0; col++) begin
                     bit taken = 0;
                     foreach (pegs[j]) if (pegs[j] == col) taken = 1;
                     if (!taken) pick = col;
                  end
               end else begin
                  pick = c - NUM_COLORS;
               end
               pegs.push_back(pick);
               rej = 0;
            end
         end
      end
      exp_code = '0;
      foreach (pegs[i]) exp_code = exp_code | (CW'(pegs[i]) << (3 * i));
   endfunction

   // Launches one code generation from IDLE/DONE, feeds samples one per FILL cycle, checks against the model.
   task automatic run_and_check(input string name, input logic [7:0] smp[$], input int glitch_at,
                                output logic [CW-1:0] got_code, output int got_n);
      logic [CW-1:0] exp_code;
      int            exp_n;
      model(smp, exp_code, exp_n);
      start = 1'b1;
      tick;
      start = 1'b0;
      n_checks++;
      if ({code_valid, code} !== {1'b0, CW'(0)}) begin
         n_fail++;
         $display("FAIL %s_entry: valid=%b code=%h, need valid=0 code=000", name, code_valid, code);
      end
      got_n = 0;
      while (code_valid !== 1'b1 && got_n < 300) begin
         n_checks++;
         if ({busy, rand_switch} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s_fill_flags: cycle %0d busy=%b rand_switch=%b, need 1 1",
                     name, got_n, busy, rand_switch);
         end
         rand_in = (got_n < smp.size()) ? smp[got_n] : 8'h07;
         start   = (got_n == glitch_at);
         tick;
         got_n++;
      end
      start    = 1'b0;
      got_code = code;
      n_checks++;
      if (got_n !== exp_n) begin
         n_fail++;
         $display("FAIL %s_cycles: fill took %0d cycles, need %0d", name, got_n, exp_n);
      end
      n_checks++;
      if (code !== exp_code) begin
         n_fail++;
         $display("FAIL %s_code: code=%h, need %h", name, code, exp_code);
      end
      n_checks++;
      if ({busy, rand_switch} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_done_flags: busy=%b rand_switch=%b, need 0 0", name, busy, rand_switch);
      end
   endtask

   task automatic test_reset;
      Reset   = 1'b1;
      start   = 1'b0;
      rand_in = '0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) Reset = 1'b0;
         rand_in = 8'($urandom);
         tick;
         n_checks++;
         if ({busy, rand_switch, code_valid, code} !== {3'b000, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_idle: cycle %0d busy=%b sw=%b valid=%b code=%h, need all 0",
                     i, busy, rand_switch, code_valid, code);
         end
      end
   endtask

   task automatic test_rejects;
      logic [7:0]    q[$];
      logic [CW-1:0] got;
      int            n;
      q.push_back(8'h03); q.push_back(8'h07); q.push_back(8'h05);
      q.push_back(8'h16); q.push_back(8'h00); q.push_back(8'h02);
      run_and_check("rejects", q, -1, got, n);
      n_checks++;
      if (got !== 12'h42B || n !== 6) begin
         n_fail++;
         $display("FAIL rejects_fixed: code=%h cycles=%0d, need 42b and 6", got, n);
      end
   endtask

   task automatic test_stuck_input;
      logic [7:0]    q[$];
      logic [CW-1:0] got;
      int            n;
      for (int i = 0; i < 40; i++) q.push_back(8'h07);
      run_and_check("stuck", q, -1, got, n);
      n_checks++;
      if (got !== (UNIQ ? 12'h688 : 12'h249) || n !== 32) begin
         n_fail++;
         $display("FAIL stuck_fixed: code=%h cycles=%0d, need %h and 32", got, n,
                  UNIQ ? 12'h688 : 12'h249);
      end
   endtask

   task automatic test_duplicates;
      logic [7:0]    q[$];
      logic [CW-1:0] got;
      int            n;
      q.push_back(8'h01); q.push_back(8'h01); q.push_back(8'h02);
      q.push_back(8'h03); q.push_back(8'h04);
      run_and_check("dups", q, -1, got, n);
      n_checks++;
      if (got !== (UNIQ ? 12'h8D1 : 12'h689)) begin
         n_fail++;
         $display("FAIL dups_fixed: code=%h, need %h", got, UNIQ ? 12'h8D1 : 12'h689);
      end
   endtask

   task automatic test_reset_mid_fill;
      logic [7:0]    q[$];
      logic [CW-1:0] got;
      int            n;
      start = 1'b1;
      tick;
      start   = 1'b0;
      rand_in = 8'h03;
      tick;
      Reset   = 1'b1;
      rand_in = 8'h05;
      tick;
      n_checks++;
      if ({busy, rand_switch, code_valid, code} !== {3'b000, CW'(0)}) begin
         n_fail++;
         $display("FAIL midfill_reset: busy=%b sw=%b valid=%b code=%h, need all 0",
                  busy, rand_switch, code_valid, code);
      end
      Reset = 1'b0;
      tick;
      q.push_back(8'h02); q.push_back(8'h04); q.push_back(8'h01); q.push_back(8'h05);
      run_and_check("after_reset", q, -1, got, n);
   endtask

   task automatic test_back_to_back;
      logic [7:0]    q[$];
      logic [CW-1:0] hold;
      logic [CW-1:0] got;
      int            n;
      hold = code;
      for (int i = 0; i < 4; i++) begin
         rand_in = 8'($urandom);
         tick;
         n_checks++;
         if ({code_valid, busy, code} !== {2'b10, hold}) begin
            n_fail++;
            $display("FAIL done_hold: valid=%b busy=%b code=%h, need 1 0 %h", code_valid, busy, code, hold);
         end
      end
      for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
      run_and_check("restart", q, 2, got, n);
   endtask

   task automatic test_random;
      logic [7:0]    q[$];
      logic [7:0]    b;
      logic [CW-1:0] got;
      int            n;
      for (int r = 0; r < 24; r++) begin
         q.delete();
         for (int k = 0; k < 40; k++) begin
            case (r % 3)
               0:       b = 8'($urandom);
               1:       b = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                        : {5'($urandom), 3'($urandom_range(6, 7))};
               default: b = {5'($urandom), 3'($urandom_range(0, 3))};
            endcase
            q.push_back(b);
         end
         run_and_check("random", q, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1,
                       got, n);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_rejects();
      test_stuck_input();
      test_duplicates();
      test_reset_mid_fill();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
